// File: rtl/mem_stage_pkg.sv
// Shared encodings and byte-lane helpers for the memory-access stage.
// The helpers work on 64-bit words and 8-lane masks so they serve both XLEN=32 and XLEN=64.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] RS_ALU = 2'b00;
    localparam logic [1:0] RS_MEM = 2'b01;
    localparam logic [1:0] RS_PC4 = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mstate_e;

    // Low-offset bits that must be zero for an access of 2**size bytes.
    function automatic logic [2:0] size_mask(input logic [1:0] size);
        return 3'((4'd1 << size) - 4'd1);
    endfunction

    function automatic logic [2:0] align_off(input logic [1:0] size, input logic [2:0] off);
        return off & ~size_mask(size);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        return (off & size_mask(size)) != 3'd0;
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        base = 8'((16'd1 << (4'd1 << size)) - 16'd1);
        return base << off;
    endfunction

    function automatic logic [63:0] load_extract(input logic [63:0] word, input logic [2:0] off,
                                                 input logic [1:0] size, input logic uns);
        logic [63:0] sh;
        logic [63:0] res;
        sh = word >> {off, 3'b000};
        case (size)
            2'd0:    res = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
            2'd1:    res = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'd2:    res = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/byte_lane_dmem.sv
// Data memory: DEPTH_WORDS x XLEN, per-byte write enables, combinational read.
// Contents are deliberately not reset.
module byte_lane_dmem #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    localparam int NB = XLEN / 8,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [NB-1:0]   be_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline M stage: byte-lane loads/stores with optional MEM_LAT wait states.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned H/W/D accesses (adds MisalignW).
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int MEM_LAT     = 0
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            ValidM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [4:0]      RdM,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic [2:0]      Funct3M,
    input  logic            MemWriteM,
    input  logic            MemReadM,
    input  logic            RegWriteM,
    input  logic [1:0]      ResultSrcM,
    output logic [XLEN-1:0] ALUResultMH,
    output logic            StallM,
    output logic            ValidW,
    output logic [XLEN-1:0] ALUResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [XLEN-1:0] PCPlus4W,
    output logic [4:0]      RdW,
    output logic            RegWriteW,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic            MisalignW,
`endif
    output logic [1:0]      ResultSrcW
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int AW   = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT = 4'(MEM_LAT);

    mstate_e         state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [1:0]      size;
    logic            uns;
    logic [2:0]      off_raw, off;
    logic            mis, mem_op, stall, we;
    logic [NB-1:0]   be;
    logic [XLEN-1:0] wdata, rword, rd_val;

    assign size    = Funct3M[1:0];
    assign uns     = Funct3M[2];
    assign off_raw = 3'(ALUResultM[OFFW-1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis = ValidM & (MemReadM | MemWriteM) & is_misaligned(size, off_raw);
    assign off = off_raw;
`else
    assign mis = 1'b0;
    assign off = align_off(size, off_raw);
`endif

    assign mem_op = ValidM & (MemReadM | MemWriteM) & ~mis;

    // Counter holds the wait cycles still owed; the access completes when it reaches 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (LAT != 4'd0 && mem_op) begin
                    state_d = ST_BUSY;
                    cnt_d   = LAT;
                    stall   = 1'b1;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d != 4'd0) stall = 1'b1;
                else               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!RST_N) stall = 1'b0;
    end

    assign StallM      = stall;
    assign ALUResultMH = ALUResultM;

    // Shifting the store data puts its low bytes onto exactly the enabled lanes.
    assign we    = mem_op & MemWriteM & ~stall & RST_N;
    assign be    = NB'(lane_mask(size, off));
    assign wdata = WriteDataM << {off, 3'b000};

    byte_lane_dmem #(
        .XLEN        (XLEN),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_dmem (
        .clk_i   (CLK),
        .we_i    (we),
        .be_i    (be),
        .addr_i  (ALUResultM[AW+OFFW-1:OFFW]),
        .wdata_i (wdata),
        .rdata_o (rword)
    );

    assign rd_val = (MemReadM & ~MemWriteM & ~mis)
                  ? XLEN'(load_extract(64'(rword), off, size, uns)) : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ValidW     <= 1'b0;
            RegWriteW  <= 1'b0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            ResultSrcW <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            MisalignW  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ValidW     <= ValidM & ~stall;
            RegWriteW  <= ValidM & RegWriteM & ~stall & ~mis;
            ALUResultW <= ALUResultM;
            ReadDataW  <= rd_val;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            ResultSrcW <= ResultSrcM;
`ifdef MEM_MISALIGN_TRAP_EN
            MisalignW  <= mis;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench: instance 0 has MEM_LAT=0, instance 1 has MEM_LAT=3; a byte-array
// model predicts every cycle's StallM and the next cycle's W outputs.
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 1024;
    localparam int MEMB  = DEPTH * 4;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    logic        ValidM [2], MemWriteM [2], MemReadM [2], RegWriteM [2];
    logic [31:0] ALUResultM [2], WriteDataM [2], PCPlus4M [2];
    logic [4:0]  RdM [2];
    logic [2:0]  Funct3M [2];
    logic [1:0]  ResultSrcM [2];
    logic [31:0] ALUResultMH [2], ALUResultW [2], ReadDataW [2], PCPlus4W [2];
    logic        StallM [2], ValidW [2], RegWriteW [2];
    logic [4:0]  RdW [2];
    logic [1:0]  ResultSrcW [2];
`ifdef MEM_MISALIGN_TRAP_EN
    logic        MisalignW [2];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_access_stage #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .MEM_LAT(g * 3)) u_dut (
            .CLK(CLK), .RST_N(RST_N), .ValidM(ValidM[g]), .ALUResultM(ALUResultM[g]),
            .WriteDataM(WriteDataM[g]), .RdM(RdM[g]), .PCPlus4M(PCPlus4M[g]),
            .Funct3M(Funct3M[g]), .MemWriteM(MemWriteM[g]), .MemReadM(MemReadM[g]),
            .RegWriteM(RegWriteM[g]), .ResultSrcM(ResultSrcM[g]),
            .ALUResultMH(ALUResultMH[g]), .StallM(StallM[g]), .ValidW(ValidW[g]),
            .ALUResultW(ALUResultW[g]), .ReadDataW(ReadDataW[g]), .PCPlus4W(PCPlus4W[g]),
            .RdW(RdW[g]), .RegWriteW(RegWriteW[g]),
`ifdef MEM_MISALIGN_TRAP_EN
            .MisalignW(MisalignW[g]),
`endif
            .ResultSrcW(ResultSrcW[g]));
    end

    typedef struct {
        logic        stall, full, rdchk, vld, rw, mis;
        logic [31:0] alu, rdata, pc4;
        logic [4:0]  rd;
        logic [1:0]  rs;
    } exp_t;

    exp_t       cur [2], pend [2];
    logic       cur_ok [2], pend_ok [2];
    logic [7:0] mm [2][MEMB];
    logic [2:0] f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    int         nchk = 0;
    int         nerr = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic r, input logic w, input logic rg,
                         input logic [1:0] rs, input logic [4:0] rd, input logic [31:0] pc4);
        ValidM[d] = v; Funct3M[d] = f3; ALUResultM[d] = a; WriteDataM[d] = wd;
        MemReadM[d] = r; MemWriteM[d] = w; RegWriteM[d] = rg;
        ResultSrcM[d] = rs; RdM[d] = rd; PCPlus4M[d] = pc4;
    endtask

    task automatic idle(input int d);
        exp_t e;
        drive(d, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'd0);
        e = '{stall: 1'b0, full: 1'b1, rdchk: 1'b0, vld: 1'b0, rw: 1'b0, mis: 1'b0,
              alu: 32'd0, rdata: 32'd0, pc4: 32'd0, rd: 5'd0, rs: 2'd0};
        cur[d] = e;
        cur_ok[d] = 1'b1;
    endtask

    // One instruction, held until it completes; returns the predicted load value and
    // the number of cycles StallM was seen high.
    task automatic op(input int d, input logic v, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic r, input logic w, input logic rg,
                      input logic [1:0] rs, input logic [4:0] rd, input logic [31:0] pc4,
                      output logic [31:0] exp_rd, output int nstall);
        int nb, k, ea;
        logic mis, mop;
        logic [63:0] v64;
        exp_t e;
        nb  = 1 << f3[1:0];
        mis = 1'b0;
        ea  = int'(a % MEMB);
`ifdef MEM_MISALIGN_TRAP_EN
        mis = v && (r || w) && (ea % nb != 0);
`else
        ea  = ea / nb * nb;
`endif
        v64 = 64'd0;
        for (int i = 0; i < nb; i++) v64[8*i +: 8] = mm[d][(ea + i) % MEMB];
        if (!f3[2] && v64[8*nb-1]) v64 = v64 | (~64'd0 << (8 * nb));
        exp_rd = (r && !w && !mis) ? v64[31:0] : 32'd0;
        mop = v && (r || w) && !mis;
        k   = mop ? lat_of(d) : 0;
        e = '{stall: 1'b0, full: 1'b1, rdchk: v, vld: v, rw: v && rg && !mis, mis: mis,
              alu: a, rdata: exp_rd, pc4: pc4, rd: rd, rs: rs};
        drive(d, v, f3, a, wd, r, w, rg, rs, rd, pc4);
        nstall = 0;
        for (int i = 0; i <= k; i++) begin
            e.stall = (i < k);
            e.full  = (i == k);
            cur[d] = e;
            cur_ok[d] = 1'b1;
            #2;
            if (StallM[d]) nstall++;
            @(posedge CLK);
            #1;
        end
        if (mop && w) for (int i = 0; i < nb; i++) mm[d][(ea + i) % MEMB] = wd[8*i +: 8];
    endtask

    task automatic run(input int d);
        logic [31:0] x;
        int ns;
        for (int i = 0; i < 64; i++)
            op(d, 1'b1, F3_W, 32'(i * 4), $urandom, 1'b0, 1'b1, 1'b0, RS_ALU, 5'd0, 32'd0, x, ns);
        for (int i = 0; i < 150; i++)
            op(d, $urandom_range(0, 9) != 0, f3s[$urandom_range(0, 4)],
               ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255)), $urandom,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 2)), 5'($urandom), $urandom, x, ns);
        idle(d);
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            for (int d = 0; d < 2; d++) begin
                if (!RST_N) begin
                    chk("rst_ctl", d, 64'({StallM[d], ValidW[d], RegWriteW[d], RdW[d], ResultSrcW[d]}), 64'd0);
                    chk("rst_alu", d, 64'(ALUResultW[d]), 64'd0);
                    chk("rst_rdata", d, 64'(ReadDataW[d]), 64'd0);
                    chk("rst_pc4", d, 64'(PCPlus4W[d]), 64'd0);
`ifdef MEM_MISALIGN_TRAP_EN
                    chk("rst_mis", d, 64'(MisalignW[d]), 64'd0);
`endif
                    pend_ok[d] = 1'b0;
                end else begin
                    chk("alu_mh", d, 64'(ALUResultMH[d]), 64'(ALUResultM[d]));
                    if (pend_ok[d]) begin
                        chk("valid_w", d, 64'(ValidW[d]), 64'(pend[d].full && pend[d].vld));
                        chk("regwrite_w", d, 64'(RegWriteW[d]), 64'(pend[d].full && pend[d].rw));
                        if (pend[d].full) begin
                            chk("alu_w", d, 64'(ALUResultW[d]), 64'(pend[d].alu));
                            chk("pc4_w", d, 64'(PCPlus4W[d]), 64'(pend[d].pc4));
                            chk("rd_rs_w", d, 64'({RdW[d], ResultSrcW[d]}), 64'({pend[d].rd, pend[d].rs}));
`ifdef MEM_MISALIGN_TRAP_EN
                            chk("mis_w", d, 64'(MisalignW[d]), 64'(pend[d].mis));
`endif
                            if (pend[d].rdchk) chk("rdata_w", d, 64'(ReadDataW[d]), 64'(pend[d].rdata));
                        end
                    end
                    if (cur_ok[d]) begin
                        chk("stall", d, 64'(StallM[d]), 64'(cur[d].stall));
                        pend[d] = cur[d];
                    end
                    pend_ok[d] = cur_ok[d];
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] x;
        int ns;
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            cur_ok[d] = 1'b0;
            pend_ok[d] = 1'b0;
            idle(d);
        end
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // Byte loads from a stored word, signed and unsigned.
        op(0, 1, F3_W, 32'h10, 32'hDEADBEEF, 0, 1, 0, RS_ALU, 5'd0, 32'h0, x, ns);
        op(0, 1, F3_B, 32'h13, 32'h0, 1, 0, 1, RS_MEM, 5'd3, 32'h104, x, ns);
        chk("lb_model", 0, 64'(x), 64'hFFFF_FFDE);
        chk("lb_dut", 0, 64'(ReadDataW[0]), 64'hFFFF_FFDE);
        op(0, 1, F3_BU, 32'h13, 32'h0, 1, 0, 1, RS_MEM, 5'd4, 32'h108, x, ns);
        chk("lbu_model", 0, 64'(x), 64'h0000_00DE);
        chk("lbu_dut", 0, 64'(ReadDataW[0]), 64'h0000_00DE);

        // Half-word store merges into the upper lanes only.
        op(0, 1, F3_W, 32'h20, 32'hAABBCCDD, 0, 1, 0, RS_ALU, 5'd0, 32'h0, x, ns);
        op(0, 1, F3_H, 32'h22, 32'h1234, 0, 1, 0, RS_ALU, 5'd0, 32'h0, x, ns);
        op(0, 1, F3_W, 32'h20, 32'h0, 1, 0, 1, RS_MEM, 5'd5, 32'h10C, x, ns);
        chk("sh_merge_model", 0, 64'(x), 64'h1234_CCDD);
        chk("sh_merge_dut", 0, 64'(ReadDataW[0]), 64'h1234_CCDD);

        // Address wrap: 0x1000 aliases word 0.
        op(0, 1, F3_W, 32'h1000, 32'h5, 0, 1, 0, RS_ALU, 5'd0, 32'h0, x, ns);
        op(0, 1, F3_W, 32'h0, 32'h0, 1, 0, 1, RS_MEM, 5'd6, 32'h110, x, ns);
        chk("wrap_dut", 0, 64'(ReadDataW[0]), 64'h5);
        idle(0);

        // Wait-state load: three stall cycles, data on the following cycle.
        op(1, 1, F3_W, 32'h20, 32'h600DF00D, 0, 1, 0, RS_ALU, 5'd0, 32'h0, x, ns);
        op(1, 1, F3_W, 32'h20, 32'h0, 1, 0, 1, RS_MEM, 5'd7, 32'h200, x, ns);
        chk("lat_stalls", 1, 64'(ns), 64'd3);
        chk("lat_valid", 1, 64'(ValidW[1]), 64'd1);
        chk("lat_rdata", 1, 64'(ReadDataW[1]), 64'h600D_F00D);

`ifdef MEM_MISALIGN_TRAP_EN
        op(1, 1, F3_W, 32'h30, 32'h11223344, 0, 1, 0, RS_ALU, 5'd0, 32'h0, x, ns);
        op(1, 1, F3_W, 32'h32, 32'h0, 1, 0, 1, RS_MEM, 5'd8, 32'h204, x, ns);
        chk("mis_nostall", 1, 64'(ns), 64'd0);
        chk("mis_flag", 1, 64'({MisalignW[1], RegWriteW[1], ValidW[1]}), 64'b101);
        op(1, 1, F3_H, 32'h31, 32'hAAAA, 0, 1, 0, RS_ALU, 5'd0, 32'h0, x, ns);
        op(1, 1, F3_W, 32'h30, 32'h0, 1, 0, 1, RS_MEM, 5'd9, 32'h208, x, ns);
        chk("mis_store_suppressed", 1, 64'(ReadDataW[1]), 64'h1122_3344);
`endif

        // Reset in the middle of a store's wait cycles abandons the write.
        op(1, 1, F3_W, 32'h40, 32'h0BADC0DE, 0, 1, 0, RS_ALU, 5'd0, 32'h0, x, ns);
        drive(1, 1, F3_W, 32'h40, 32'hFFFFFFFF, 0, 1, 0, RS_ALU, 5'd0, 32'h0);
        e = '{stall: 1'b1, full: 1'b0, rdchk: 1'b0, vld: 1'b0, rw: 1'b0, mis: 1'b0,
              alu: 32'h40, rdata: 32'd0, pc4: 32'd0, rd: 5'd0, rs: 2'd0};
        cur[1] = e;
        @(posedge CLK);
        #1;
        chk("busy_before_rst", 1, 64'(StallM[1]), 64'd1);
        RST_N = 1'b0;
        idle(0);
        idle(1);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        op(1, 1, F3_W, 32'h40, 32'h0, 1, 0, 1, RS_MEM, 5'd10, 32'h20C, x, ns);
        chk("rst_idle_stalls", 1, 64'(ns), 64'd3);
        chk("rst_mem_unchanged", 1, 64'(ReadDataW[1]), 64'h0BAD_C0DE);
        idle(1);

        fork
            run(0);
            run(1);
        join
        repeat (4) @(posedge CLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
